ahb_slave_rr_burst_arbiter: RTL and testbench

// - Burst-aware round-robin arbiter for one AHB slave port; shares the slave between MASTER_NUM masters.
// - Grants ownership for a whole burst, counts beats on the slave handshake and hands over only at burst end.
// - Instantiated per slave in the interconnect, alongside the fixed and dynamic priority slave arbiters, as a drop-in option.

---
 rtl/ahb_slave_rr_burst_arbiter_pkg.sv | 39 +++
 rtl/ahb_slave_rr_burst_arbiter_rr_pick.sv | 28 ++
 rtl/ahb_slave_rr_burst_arbiter.sv | 104 ++++++++++
 tb/tb_ahb_slave_rr_burst_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_slave_rr_burst_arbiter_pkg.sv
// Shared types and helpers for the burst-aware round-robin AHB slave arbiter.
package ahb_slave_rr_burst_arbiter_pkg;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } hburst_type;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_e;

   localparam int CNT_W = 8;
   localparam int LIM_W = 9;

   // Undefined-length INCR is capped at incr_max so one master cannot hog the slave.
   function automatic logic [LIM_W-1:0] burst_beats(input hburst_type burst,
                                                    input logic [LIM_W-1:0] incr_max);
      logic [LIM_W-1:0] beats;
      beats = 9'd1;
      case (burst)
         SINGLE:         beats = 9'd1;
         INCR:           beats = incr_max;
         WRAP4, INCR4:   beats = 9'd4;
         WRAP8, INCR8:   beats = 9'd8;
         WRAP16, INCR16: beats = 9'd16;
         default:        beats = 9'd1;
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/ahb_slave_rr_burst_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr_i, wrapping.
module ahb_slave_rr_burst_arbiter_rr_pick #(
   parameter  int REQ_NUM = 4,
   localparam int IW      = $clog2(REQ_NUM)
) (
   input  logic [REQ_NUM-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [IW-1:0]      winner_o,
   output logic               any_req_o
);

   logic found;

   // The pointer's own index is scanned last, so the previous owner only wins when alone.
   always_comb begin
      winner_o = '0;
      found    = 1'b0;
      for (int i = 1; i <= REQ_NUM; i++) begin
         if (!found && req_i[(int'(ptr_i) + i) % REQ_NUM]) begin
            found    = 1'b1;
            winner_o = IW'((int'(ptr_i) + i) % REQ_NUM);
         end
      end
   end

   assign any_req_o = |req_i;

endmodule

// File: rtl/ahb_slave_rr_burst_arbiter.sv
// Burst-aware round-robin arbiter for one AHB slave port: ownership lasts a whole burst.
module ahb_slave_rr_burst_arbiter
   import ahb_slave_rr_burst_arbiter_pkg::*;
#(
   parameter  int MASTER_NUM     = 4,
   parameter  int INCR_MAX_BEATS = 16,
   localparam int MW             = $clog2(MASTER_NUM)
) (
   input  logic                       hclk,
   input  logic                       hreset_n,
   input  logic [MASTER_NUM-1:0]      hreq,
   input  logic [MASTER_NUM-1:0][2:0] hburst,
   input  logic                       hwait,
   output logic [MASTER_NUM-1:0]      hgrant,
   output logic [MW-1:0]              hmaster,
   output logic                       hsel,
   output logic                       hlast
);

   localparam logic [LIM_W-1:0] INCR_LIM = LIM_W'(INCR_MAX_BEATS);

   arb_state_e              state_q, state_d;
   logic [MASTER_NUM-1:0]   grant_q, grant_d;
   logic [MW-1:0]           master_q, master_d;
   logic [MW-1:0]           ptr_q, ptr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [LIM_W-1:0]        lim_q, lim_d;
   logic                    incr_q, incr_d;

   logic [MW-1:0]           winner;
   logic                    any_req;
   hburst_type              win_burst;
   logic                    cur_last;
   logic                    release_beat;

   ahb_slave_rr_burst_arbiter_rr_pick #(.REQ_NUM(MASTER_NUM)) u_rr_pick (
      .req_i     (hreq),
      .ptr_i     (ptr_q),
      .winner_o  (winner),
      .any_req_o (any_req)
   );

   assign win_burst    = hburst_type'(hburst[winner]);
   assign cur_last     = ({1'b0, cnt_q} == (lim_q - LIM_W'(1)));
   assign release_beat = (state_q == OWN) && !hwait
                         && (cur_last || (incr_q && !hreq[master_q]));

   // NOTE: every variable gets its hold value first so no path through this block infers a latch.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      master_d = master_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      lim_d    = lim_q;
      incr_d   = incr_q;
      if (state_q == IDLE || release_beat) begin
         if (any_req) begin
            state_d         = OWN;
            grant_d         = '0;
            grant_d[winner] = 1'b1;
            master_d        = winner;
            ptr_d           = winner;
            cnt_d           = '0;
            lim_d           = burst_beats(win_burst, INCR_LIM);
            incr_d          = (win_burst == INCR);
         end else begin
            state_d = IDLE;
            grant_d = '0;
         end
      end else if (!hwait) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from the same old values.
   always_ff @(posedge hclk) begin
      if (!hreset_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         master_q <= '0;
         ptr_q    <= MW'(MASTER_NUM - 1);
         cnt_q    <= '0;
         lim_q    <= 9'd1;
         incr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         master_q <= master_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         lim_q    <= lim_d;
         incr_q   <= incr_d;
      end
   end

   assign hgrant  = grant_q;
   assign hmaster = master_q;
   assign hsel    = |grant_q;
   assign hlast   = hsel & cur_last;

   grant_onehot_a : assert property (@(posedge hclk) disable iff (!hreset_n) $onehot0(grant_q));

endmodule

// File: tb/tb_ahb_slave_rr_burst_arbiter.sv
// Self-checking bench: directed scenarios with fixed expectations plus a randomized run against a cycle model.
module tb_ahb_slave_rr_burst_arbiter;

   localparam int N   = 4;
   localparam int IMB = 16;

   logic               hclk;
   logic               hreset_n;
   logic [N-1:0]       hreq;
   logic [N-1:0][2:0]  hburst;
   logic               hwait;
   logic [N-1:0]       hgrant;
   logic [1:0]         hmaster;
   logic               hsel;
   logic               hlast;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: owner index (-1 = none), beats done, burst length, INCR flag, last winner.
   int m_owner = -1;
   int m_cnt   = 0;
   int m_lim   = 1;
   bit m_incr  = 0;
   int m_last  = N - 1;

   ahb_slave_rr_burst_arbiter #(.MASTER_NUM(N), .INCR_MAX_BEATS(IMB)) dut (
      .hclk     (hclk),
      .hreset_n (hreset_n),
      .hreq     (hreq),
      .hburst   (hburst),
      .hwait    (hwait),
      .hgrant   (hgrant),
      .hmaster  (hmaster),
      .hsel     (hsel),
      .hlast    (hlast)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   // AHB encoding: 0 SINGLE, 1 INCR, then WRAP/INCR pairs of 4, 8, 16 beats.
   function automatic int beats_of(input int b);
      if (b == 0) return 1;
      if (b == 1) return IMB;
      return 4 << ((b - 2) / 2);
   endfunction

   task automatic model_update();
      bit pick;
      if (!hreset_n) begin
         m_owner = -1;
         m_cnt   = 0;
         m_last  = N - 1;
      end else begin
         pick = (m_owner < 0) ||
                (!hwait && ((m_cnt == m_lim - 1) || (m_incr && !hreq[m_owner])));
         if (pick) begin
            m_owner = -1;
            for (int k = 1; k <= N; k++) begin
               if (m_owner < 0 && hreq[(m_last + k) % N]) m_owner = (m_last + k) % N;
            end
            if (m_owner >= 0) begin
               m_cnt  = 0;
               m_lim  = beats_of(int'(hburst[m_owner]));
               m_incr = (hburst[m_owner] == 3'd1);
               m_last = m_owner;
            end
         end else if (!hwait) begin
            m_cnt++;
         end
      end
   endtask

   function automatic logic [7:0] model_outputs();
      logic [3:0] g;
      logic [1:0] m;
      logic       l;
      g = '0;
      m = '0;
      l = 1'b0;
      if (m_owner >= 0) begin
         g[m_owner] = 1'b1;
         m          = 2'(m_owner);
         l          = (m_cnt == m_lim - 1);
      end
      return {g, (m_owner >= 0), l, m};
   endfunction

   task automatic tick();
      @(posedge hclk);
      model_update();
      #1;
   endtask

   task automatic do_reset(input logic [N-1:0] req);
      hreset_n = 1'b0;
      hreq     = req;
      hwait    = 1'b0;
      tick();
      hreset_n = 1'b1;
   endtask

   task automatic test_reset();
      hreset_n = 1'b0;
      hreq     = 4'b1111;
      hburst   = '0;
      hwait    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (hgrant !== 4'b0000 || hsel !== 1'b0 || hlast !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold cycle %0d: hgrant=%b hsel=%b hlast=%b, want 0000 0 0",
                     i, hgrant, hsel, hlast);
         end
      end
      hreset_n = 1'b1;
      tick();
      vectors++;
      if (hgrant !== 4'b0001 || hsel !== 1'b1 || hmaster !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_first_grant: hgrant=%b hsel=%b hmaster=%0d, want 0001 1 0",
                  hgrant, hsel, hmaster);
      end
   endtask

   task automatic test_fairness();
      logic [3:0] want;
      hburst = '0;
      do_reset(4'b1111);
      for (int i = 0; i < 5; i++) begin
         tick();
         want = 4'b0001 << (i % N);
         vectors++;
         if (hgrant !== want || hlast !== 1'b1 || hmaster !== 2'(i % N)) begin
            miscompares++;
            $display("FAIL fairness step %0d: hgrant=%b hlast=%b hmaster=%0d, want %b 1 %0d",
                     i, hgrant, hlast, hmaster, want, i % N);
         end
      end
   endtask

   task automatic test_fixed_burst_waits();
      logic waits [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      hburst    = '0;
      hburst[2] = 3'd3;
      do_reset(4'b0000);
      hreq = 4'b0100;
      tick();
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (hgrant !== 4'b0100 || hlast !== (i == 5)) begin
            miscompares++;
            $display("FAIL fixed_burst cycle %0d: hgrant=%b hlast=%b, want 0100 %b",
                     i, hgrant, hlast, (i == 5));
         end
         hwait = waits[i];
         hreq  = 4'b0000;
         tick();
      end
      vectors++;
      if (hgrant !== 4'b0000 || hsel !== 1'b0) begin
         miscompares++;
         $display("FAIL fixed_burst_release: hgrant=%b hsel=%b, want 0000 0", hgrant, hsel);
      end
   endtask

   task automatic test_incr_early_stop();
      hburst    = '0;
      hburst[1] = 3'd1;
      do_reset(4'b0000);
      hreq = 4'b0010;
      tick();
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (hgrant !== 4'b0010 || hlast !== 1'b0) begin
            miscompares++;
            $display("FAIL incr_early beat %0d: hgrant=%b hlast=%b, want 0010 0", i, hgrant, hlast);
         end
         hreq = (i == 5) ? 4'b1000 : 4'b1010;
         tick();
      end
      vectors++;
      if (hgrant !== 4'b1000 || hsel !== 1'b1 || hmaster !== 2'd3) begin
         miscompares++;
         $display("FAIL incr_early_handover: hgrant=%b hsel=%b hmaster=%0d, want 1000 1 3",
                  hgrant, hsel, hmaster);
      end
   endtask

   task automatic test_incr_limit();
      hburst    = '0;
      hburst[0] = 3'd1;
      do_reset(4'b0000);
      hreq = 4'b0001;
      tick();
      for (int i = 0; i < IMB; i++) begin
         vectors++;
         if (hgrant !== 4'b0001 || hlast !== (i == IMB - 1)) begin
            miscompares++;
            $display("FAIL incr_limit beat %0d: hgrant=%b hlast=%b, want 0001 %b",
                     i, hgrant, hlast, (i == IMB - 1));
         end
         tick();
      end
      vectors++;
      if (hgrant !== 4'b0001 || hlast !== 1'b0) begin
         miscompares++;
         $display("FAIL incr_limit_regrant: hgrant=%b hlast=%b, want 0001 0", hgrant, hlast);
      end
   endtask

   task automatic test_mid_burst_reset();
      hburst    = '0;
      hburst[3] = 3'd5;
      do_reset(4'b0000);
      hreq = 4'b1000;
      tick();
      for (int i = 0; i < 4; i++) tick();
      vectors++;
      if (hgrant !== 4'b1000 || hlast !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_beat4: hgrant=%b hlast=%b, want 1000 0", hgrant, hlast);
      end
      hburst   = '0;
      hreq     = 4'b1111;
      hreset_n = 1'b0;
      tick();
      vectors++;
      if (hgrant !== 4'b0000 || hsel !== 1'b0 || hlast !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_drop: hgrant=%b hsel=%b hlast=%b, want 0000 0 0",
                  hgrant, hsel, hlast);
      end
      hreset_n = 1'b1;
      tick();
      vectors++;
      if (hgrant !== 4'b0001) begin
         miscompares++;
         $display("FAIL mid_reset_restart: hgrant=%b, want 0001", hgrant);
      end
   endtask

   task automatic test_random();
      logic [7:0] obs;
      logic [7:0] want;
      hburst = '0;
      do_reset(4'b0000);
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < N; k++) begin
            hreq[k]   = ($urandom_range(0, 4) != 0);
            hburst[k] = 3'($urandom_range(0, 7));
         end
         hwait    = ($urandom_range(0, 3) == 0);
         hreset_n = ($urandom_range(0, 99) != 0);
         tick();
         want = model_outputs();
         obs  = {hgrant, hsel, hlast, (hsel ? hmaster : 2'b00)};
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL random cycle %0d: {hgrant,hsel,hlast,hmaster}=%b, want %b",
                     c, obs, want);
         end
      end
      hreset_n = 1'b1;
   endtask

   initial begin
      hreset_n = 1'b0;
      hreq     = '0;
      hburst   = '0;
      hwait    = 1'b0;
      test_reset();
      test_fairness();
      test_fixed_burst_waits();
      test_incr_early_stop();
      test_incr_limit();
      test_mid_burst_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
